bp_update_sched: RTL
====================

# bp_update_sched

Write-port scheduler for the branch predictor tables (BTB and agree-PHT). It owns both table write ports and arbitrates between two sources: commit-stage update packets, and an internal clear sweep that runs after reset and on a flush request (e.g. FENCE.I). Update packets are buffered in a small FIFO so that updates arriving during a sweep are applied, in order, once the sweep finishes. Fetch reads `busy_o` and must ignore predictor outputs (PC+4 only) while it is high.

## Interface
- `INDEX_WIDTH`, 6, BTB index width; BTB has 2^INDEX_WIDTH entries.
- `HISTORY_WIDTH`, 8, PHT index width; PHT has 2^HISTORY_WIDTH entries.
- `FIFO_DEPTH`, 4, number of update-FIFO entries; a power of two, ≥2.
- Derived: CNT_W = max(INDEX_WIDTH, HISTORY_WIDTH); TAG_W = 32-INDEX_WIDTH-2.

Ports:
- `clk_i` in 1: clock. One clock domain.
- `rst_ni` in 1: reset, synchronous, active-low.
- `flush_req_i` in 1: single-cycle request to clear all predictor state.
- `upd_valid_i` in 1: update packet valid.
- `upd_ready_o` out 1: `!fifo_full && !flush_req_i`.
- `upd_btb_wr_i` in 1: packet also writes the BTB (BTB miss on a branch).
- `upd_btb_index_i` in INDEX_WIDTH: BTB write index.
- `upd_btb_tag_i` in TAG_W: BTB tag.
- `upd_btb_target_i` in 32: BTB target.
- `upd_pht_index_i` in HISTORY_WIDTH: PHT write index (already hashed with the GHR).
- `upd_pht_agree_i` in 1: outcome agreed with the bias bit.
- `btb_we_o` out 1: BTB write enable.
- `btb_idx_o` out INDEX_WIDTH: BTB write index.
- `btb_tag_o` out TAG_W: BTB write tag.
- `btb_target_o` out 32: BTB write target.
- `btb_valid_o` out 1: valid bit to write.
- `pht_we_o` out 1: PHT write enable.
- `pht_idx_o` out HISTORY_WIDTH: PHT write index.
- `pht_init_o` out 1: 1 means force the counter to 2'b10 (weak agree); 0 means apply a saturating update.
- `pht_agree_o` out 1: update direction (1 = increment).
- `busy_o` out 1: sweep in progress.
- `done_o` out 1: one-cycle pulse when a sweep completes.

## Operation
- States:
  - SWEEP: counter `cnt` (CNT_W bits) runs 0 .. 2^CNT_W-1, one entry per cycle.
    - Each cycle: `btb_we_o` = (cnt < 2^INDEX_WIDTH), `btb_idx_o` = cnt[INDEX_WIDTH-1:0], `btb_valid_o` = 0, tag/target = 0.
    - Each cycle: `pht_we_o` = (cnt < 2^HISTORY_WIDTH), `pht_idx_o` = cnt[HISTORY_WIDTH-1:0], `pht_init_o` = 1.
    - After cnt = 2^CNT_W-1 is issued, go to IDLE.
  - IDLE: if the FIFO is non-empty, pop the head and issue it.
    - `pht_we_o` = 1, `pht_init_o` = 0, `pht_agree_o` = packet agree bit.
    - `btb_we_o` = packet `btb_wr`, `btb_valid_o` = 1, tag/target/index taken from the packet.
    - Throughput: one packet per cycle.
- FIFO:
  - Pushes are accepted in any state while `upd_ready_o` is high.
  - In SWEEP it only fills; it drains only in IDLE.
  - A simultaneous push and pop on a full FIFO is allowed. `upd_ready_o` reflects the pre-pop count, so no push is accepted on a full FIFO even when a pop happens in the same cycle.
- Flush (`flush_req_i` = 1):
  - Clears the FIFO.
  - Drops any in-flight pop; nothing is issued from the FIFO that cycle.
  - Sets cnt = 0 and enters SWEEP.
  - A flush during SWEEP restarts the sweep from 0.
  - The flush has priority over everything else.
- Reset (`rst_ni` = 0 at an edge): state = SWEEP, cnt = 0, FIFO empty. Registered outputs reset to: all `*_we_o` = 0, `done_o` = 0, `busy_o` = 1, data outputs = 0.
- Reset mid-sweep or mid-drain: same as above. FIFO contents are lost.

## Timing
- All table-port outputs, `busy_o` and `done_o` are registered. `upd_ready_o` is combinational.
- Sweep timing (edge k = k-th rising edge at which the block is in SWEEP with cnt = k-1 issued):
  - Writes for cnt = 0 .. 2^CNT_W-1 are visible after edges 1 .. 2^CNT_W.
  - After edge 2^CNT_W+1: `busy_o` = 0, `done_o` = 1 for exactly one cycle, all `we` = 0 unless a FIFO pop issues in that same cycle.
  - The first FIFO pop after a sweep is visible after edge 2^CNT_W+1.
- Update latency in IDLE with an empty FIFO: push at edge N, write visible after edge N+1, so two edges.
- Flush at edge F: no write is visible after F. cnt = 0 writes are visible after F+1. `busy_o` = 1 from F.
- Ordering: packets are written in acceptance order. A sweep write and a packet write never occur in the same cycle.

## Test plan
- Reset, INDEX_WIDTH=2, HISTORY_WIDTH=3 → 8 sweep cycles. BTB writes idx 0..3 only in cycles 1..4 with valid=0. PHT writes idx 0..7 with init=1. `done_o` pulses in cycle 9 and `busy_o` falls in that same cycle.
- IDLE, push {btb_wr=1, idx=2, tag=0x5, target=0x100, pht_idx=6, agree=1} → exactly one cycle with btb_we=1/valid=1 and pht_we=1/init=0/agree=1 after edge N+1.
- Push 6 packets back-to-back during a sweep with FIFO_DEPTH=4 → ready drops after 4 accepts, the remaining 2 are held off. After `done_o`, 4 writes issue in order on consecutive cycles, then the held packets follow.
- Flush at cnt=5 → the next write is cnt=0. The sweep completes 2^CNT_W cycles after the flush. `done_o` does not pulse for the aborted sweep.
- FIFO holds 3 entries in IDLE, flush with `upd_valid_i`=1 → ready=0 that cycle, FIFO emptied, none of the 3 packets is ever written.
- Assert `rst_ni`=0 mid-drain → all we=0 and `busy_o`=1 next cycle. A fresh full sweep follows and no stale packet is issued.

Source files
------------

// File: rtl/bp_update_sched_if.sv
// rtl/bp_update_sched_if.sv - commit-update and predictor-table write-port bundle
interface bp_update_sched_if #(
  parameter int INDEX_WIDTH   = 6,
  parameter int HISTORY_WIDTH = 8
) ();
  localparam int TAG_W = 32 - INDEX_WIDTH - 2;

  logic                     flush_req_i;
  logic                     upd_valid_i;
  logic                     upd_ready_o;
  logic                     upd_btb_wr_i;
  logic [INDEX_WIDTH-1:0]   upd_btb_index_i;
  logic [TAG_W-1:0]         upd_btb_tag_i;
  logic [31:0]              upd_btb_target_i;
  logic [HISTORY_WIDTH-1:0] upd_pht_index_i;
  logic                     upd_pht_agree_i;

  logic                     btb_we_o;
  logic [INDEX_WIDTH-1:0]   btb_idx_o;
  logic [TAG_W-1:0]         btb_tag_o;
  logic [31:0]              btb_target_o;
  logic                     btb_valid_o;
  logic                     pht_we_o;
  logic [HISTORY_WIDTH-1:0] pht_idx_o;
  logic                     pht_init_o;
  logic                     pht_agree_o;
  logic                     busy_o;
  logic                     done_o;

  // Commit stage / fetch side: drives updates and flushes, observes the write ports
  modport master (
    output flush_req_i, upd_valid_i, upd_btb_wr_i, upd_btb_index_i, upd_btb_tag_i,
           upd_btb_target_i, upd_pht_index_i, upd_pht_agree_i,
    input  upd_ready_o, btb_we_o, btb_idx_o, btb_tag_o, btb_target_o, btb_valid_o,
           pht_we_o, pht_idx_o, pht_init_o, pht_agree_o, busy_o, done_o
  );

  // Scheduler side
  modport slave (
    input  flush_req_i, upd_valid_i, upd_btb_wr_i, upd_btb_index_i, upd_btb_tag_i,
           upd_btb_target_i, upd_pht_index_i, upd_pht_agree_i,
    output upd_ready_o, btb_we_o, btb_idx_o, btb_tag_o, btb_target_o, btb_valid_o,
           pht_we_o, pht_idx_o, pht_init_o, pht_agree_o, busy_o, done_o
  );
endinterface

// File: rtl/bp_update_sched.sv
// rtl/bp_update_sched.sv - BTB/PHT write-port scheduler with clear sweep and update FIFO
module bp_update_sched #(
  parameter int INDEX_WIDTH   = 6,
  parameter int HISTORY_WIDTH = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  bp_update_sched_if.slave   bus
);
  localparam int CNT_W       = (INDEX_WIDTH > HISTORY_WIDTH) ? INDEX_WIDTH : HISTORY_WIDTH;
  localparam int TAG_W       = 32 - INDEX_WIDTH - 2;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int BTB_ENTRIES = 1 << INDEX_WIDTH;
  localparam int PHT_ENTRIES = 1 << HISTORY_WIDTH;

  typedef enum logic {ST_SWEEP, ST_IDLE} state_t;

  typedef struct packed {
    logic                     btb_wr;
    logic [INDEX_WIDTH-1:0]   btb_idx;
    logic [TAG_W-1:0]         tag;
    logic [31:0]              target;
    logic [HISTORY_WIDTH-1:0] pht_idx;
    logic                     agree;
  } pkt_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               finish_q, finish_d;

  pkt_t               mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]     count_q;
  logic               fifo_full, fifo_empty, push, pop, flush;
  pkt_t               in_pkt, head;

  logic                     btb_we_d, btb_we_q, btb_valid_d, btb_valid_q;
  logic [INDEX_WIDTH-1:0]   btb_idx_d, btb_idx_q;
  logic [TAG_W-1:0]         btb_tag_d, btb_tag_q;
  logic [31:0]              btb_target_d, btb_target_q;
  logic                     pht_we_d, pht_we_q, pht_init_d, pht_init_q;
  logic                     pht_agree_d, pht_agree_q;
  logic [HISTORY_WIDTH-1:0] pht_idx_d, pht_idx_q;
  logic                     busy_d, busy_q, done_d, done_q;

  assign flush      = bus.flush_req_i;
  assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // Ready uses the pre-pop occupancy so a full FIFO never accepts, even while popping
  assign bus.upd_ready_o = !fifo_full && !flush;
  assign push = bus.upd_valid_i && bus.upd_ready_o;
  assign pop  = (state_q == ST_IDLE) && !fifo_empty && !flush;
  assign head = mem_q[rd_ptr_q];

  assign in_pkt = '{btb_wr:  bus.upd_btb_wr_i,
                    btb_idx: bus.upd_btb_index_i,
                    tag:     bus.upd_btb_tag_i,
                    target:  bus.upd_btb_target_i,
                    pht_idx: bus.upd_pht_index_i,
                    agree:   bus.upd_pht_agree_i};

  // State register: sweep/idle, sweep counter and the end-of-sweep marker
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_SWEEP;
      cnt_q    <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      finish_q <= finish_d;
    end
  end

  // Next state: flush restarts the sweep; the sweep ends after the last counter value
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    finish_d = 1'b0;
    if (flush) begin
      state_d = ST_SWEEP;
      cnt_d   = '0;
    end else if (state_q == ST_SWEEP) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        state_d  = ST_IDLE;
        finish_d = 1'b1;
      end
    end
  end

  // FIFO storage: entries are written only on an accepted push
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_pkt;
  end

  // FIFO pointers and occupancy; flush discards everything queued
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // Outputs: sweep write, FIFO-head write, or nothing; flush suppresses all writes
  always_comb begin
    btb_we_d     = 1'b0;
    btb_idx_d    = '0;
    btb_tag_d    = '0;
    btb_target_d = '0;
    btb_valid_d  = 1'b0;
    pht_we_d     = 1'b0;
    pht_idx_d    = '0;
    pht_init_d   = 1'b0;
    pht_agree_d  = 1'b0;
    busy_d       = (state_q == ST_SWEEP) || flush;
    done_d       = finish_q && !flush;
    if (!flush) begin
      if (state_q == ST_SWEEP) begin
        btb_we_d   = ({1'b0, cnt_q} < (CNT_W+1)'(BTB_ENTRIES));
        btb_idx_d  = cnt_q[INDEX_WIDTH-1:0];
        pht_we_d   = ({1'b0, cnt_q} < (CNT_W+1)'(PHT_ENTRIES));
        pht_idx_d  = cnt_q[HISTORY_WIDTH-1:0];
        pht_init_d = 1'b1;
      end else if (pop) begin
        btb_we_d     = head.btb_wr;
        btb_idx_d    = head.btb_idx;
        btb_tag_d    = head.tag;
        btb_target_d = head.target;
        btb_valid_d  = 1'b1;
        pht_we_d     = 1'b1;
        pht_idx_d    = head.pht_idx;
        pht_agree_d  = head.agree;
      end
    end
  end

  // Output register: every table-port signal, busy and done leave from flops
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      btb_we_q     <= 1'b0;
      btb_idx_q    <= '0;
      btb_tag_q    <= '0;
      btb_target_q <= '0;
      btb_valid_q  <= 1'b0;
      pht_we_q     <= 1'b0;
      pht_idx_q    <= '0;
      pht_init_q   <= 1'b0;
      pht_agree_q  <= 1'b0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      btb_we_q     <= btb_we_d;
      btb_idx_q    <= btb_idx_d;
      btb_tag_q    <= btb_tag_d;
      btb_target_q <= btb_target_d;
      btb_valid_q  <= btb_valid_d;
      pht_we_q     <= pht_we_d;
      pht_idx_q    <= pht_idx_d;
      pht_init_q   <= pht_init_d;
      pht_agree_q  <= pht_agree_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.btb_we_o     = btb_we_q;
  assign bus.btb_idx_o    = btb_idx_q;
  assign bus.btb_tag_o    = btb_tag_q;
  assign bus.btb_target_o = btb_target_q;
  assign bus.btb_valid_o  = btb_valid_q;
  assign bus.pht_we_o     = pht_we_q;
  assign bus.pht_idx_o    = pht_idx_q;
  assign bus.pht_init_o   = pht_init_q;
  assign bus.pht_agree_o  = pht_agree_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
endmodule
